// File: rtl/gem_pkg.sv
// Shared definitions for the GEM cluster to eighth-strip sequencer: cluster word layout,
// table sizes, ROM timing and the sequencer state/tag types.
package gem_pkg;

  localparam int unsigned MXCLUSTERS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MXADRB     = 8;
  localparam int unsigned MXDATB     = 10;
  localparam int unsigned MXPADS     = 192;
  localparam int unsigned ROM_LAT    = 1;

  localparam int unsigned PAD_LSB  = 0;
  localparam int unsigned PAD_MSB  = 7;
  localparam int unsigned ROLL_LSB = 8;
  localparam int unsigned ROLL_MSB = 10;
  localparam int unsigned SIZE_LSB = 11;
  localparam int unsigned SIZE_MSB = 13;
  localparam int unsigned CLST_W   = 14;

  localparam int unsigned DRAIN_W = 2;

  localparam logic [MXADRB-1:0]  PAD_LAST   = MXADRB'(MXPADS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(MXCLUSTERS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROM_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

  // Travels alongside each ROM address; live marks a real issue slot.
  typedef struct packed {
    logic             live;
    logic [IDX_W-1:0] idx;
    logic             valid;
  } tag_t;

endpackage

// File: rtl/gem_cluster_edge.sv
// Decodes one cluster word into first/last pad ROM addresses, clipping the last pad to the
// final valid pad and flagging empty clusters.
module gem_cluster_edge
  import gem_pkg::*;
(
  input  logic [CLST_W-1:0] cluster,
  output logic [MXADRB-1:0] first_pad,
  output logic [MXADRB-1:0] last_pad,
  output logic              valid
);

  logic [MXADRB-1:0] pad;
  logic [2:0]        size;
  logic [MXADRB:0]   sum;
  logic              unused_roll;

  assign pad         = cluster[PAD_MSB:PAD_LSB];
  assign size        = cluster[SIZE_MSB:SIZE_LSB];
  assign unused_roll = ^cluster[ROLL_MSB:ROLL_LSB];

  always_comb begin
    valid     = (pad <= PAD_LAST);
    sum       = {1'b0, pad} + (MXADRB + 1)'(size);
    first_pad = '0;
    last_pad  = '0;
    if (valid) begin
      first_pad = pad;
      last_pad  = (sum > {1'b0, PAD_LAST}) ? PAD_LAST : sum[MXADRB-1:0];
    end
  end

endmodule

// File: rtl/gem_cluster_es_seq.sv
// Walks a latched set of GEM clusters through the dual-port pad-to-ES ROM and publishes a
// double-buffered per-cluster min/max eighth-strip window set.
module gem_cluster_es_seq
  import gem_pkg::*;
(
  input  logic                         clock,
  input  logic                         global_reset,
  input  logic                         clst_start,
  input  logic [CLST_W*MXCLUSTERS-1:0] clst_in,
  output logic [MXADRB-1:0]            rom_adr0,
  output logic [MXADRB-1:0]            rom_adr1,
  input  logic [MXDATB-1:0]            rom_rd0,
  input  logic [MXDATB-1:0]            rom_rd1,
  output logic                         busy,
  output logic                         es_done,
  output logic [MXCLUSTERS-1:0]        es_vld,
  output logic [MXDATB*MXCLUSTERS-1:0] es_lo,
  output logic [MXDATB*MXCLUSTERS-1:0] es_hi,
  output logic                         start_lost
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 load_out;
  logic                 start_lost_q;
  logic [CLST_W-1:0]    clst_q [MXCLUSTERS];

  logic [MXADRB-1:0]    edge_first, edge_last;
  logic                 edge_valid;
  logic                 issue;
  tag_t                 new_tag, cap;
  tag_t                 tag_q [ROM_LAT+1];
  logic [MXDATB-1:0]    cap_lo, cap_hi;

  logic [MXDATB-1:0]    work_lo_q [MXCLUSTERS];
  logic [MXDATB-1:0]    work_hi_q [MXCLUSTERS];
  logic [MXDATB-1:0]    work_lo_d [MXCLUSTERS];
  logic [MXDATB-1:0]    work_hi_d [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] work_vld_q, work_vld_d;
  logic [MXDATB-1:0]    out_lo_q [MXCLUSTERS];
  logic [MXDATB-1:0]    out_hi_q [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] out_vld_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    load_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clst_start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d  = StDone;
          load_out = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      drain_q      <= '0;
      start_lost_q <= 1'b0;
      clst_q       <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      if (clst_start && (state_q != StIdle)) start_lost_q <= 1'b1;
      if (clst_start && (state_q == StIdle)) begin
        for (int i = 0; i < MXCLUSTERS; i++) clst_q[i] <= clst_in[i*CLST_W +: CLST_W];
      end
    end
  end

  gem_cluster_edge u_edge (
    .cluster   (clst_q[idx_q]),
    .first_pad (edge_first),
    .last_pad  (edge_last),
    .valid     (edge_valid)
  );

  assign issue = (state_q == StScan);

  always_comb begin
    new_tag = '0;
    if (issue) begin
      new_tag.live  = 1'b1;
      new_tag.idx   = idx_q;
      new_tag.valid = edge_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      rom_adr0 <= '0;
      rom_adr1 <= '0;
      tag_q    <= '{default: '0};
    end else begin
      rom_adr0 <= issue ? edge_first : '0;
      rom_adr1 <= issue ? edge_last : '0;
      tag_q[0] <= new_tag;
      for (int unsigned i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The table is not monotonic across the ME1b/ME1a boundary, so order the two reads.
  assign cap    = tag_q[ROM_LAT];
  assign cap_lo = (rom_rd0 < rom_rd1) ? rom_rd0 : rom_rd1;
  assign cap_hi = (rom_rd0 < rom_rd1) ? rom_rd1 : rom_rd0;

  always_comb begin
    work_lo_d  = work_lo_q;
    work_hi_d  = work_hi_q;
    work_vld_d = work_vld_q;
    if (cap.live) begin
      work_lo_d[cap.idx]  = cap.valid ? cap_lo : '0;
      work_hi_d[cap.idx]  = cap.valid ? cap_hi : '0;
      work_vld_d[cap.idx] = cap.valid;
    end
  end

  // Output bank loads from the next-state working bank so the final capture is included.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      work_lo_q  <= '{default: '0};
      work_hi_q  <= '{default: '0};
      work_vld_q <= '0;
      out_lo_q   <= '{default: '0};
      out_hi_q   <= '{default: '0};
      out_vld_q  <= '0;
    end else begin
      work_lo_q  <= work_lo_d;
      work_hi_q  <= work_hi_d;
      work_vld_q <= work_vld_d;
      if (load_out) begin
        out_lo_q  <= work_lo_d;
        out_hi_q  <= work_hi_d;
        out_vld_q <= work_vld_d;
      end
    end
  end

  for (genvar g = 0; g < MXCLUSTERS; g++) begin : g_out
    assign es_lo[g*MXDATB +: MXDATB] = out_lo_q[g];
    assign es_hi[g*MXDATB +: MXDATB] = out_hi_q[g];
  end

  assign es_vld     = out_vld_q;
  assign busy       = (state_q != StIdle);
  assign es_done    = (state_q == StDone);
  assign start_lost = start_lost_q;

endmodule

// File: tb/tb_gem_cluster_es_seq.sv
// Randomised and directed bench for gem_cluster_es_seq against a set-level reference model
// fed by a registered pad-to-ES ROM loaded with rom[p] = 4p + 2.
module tb_gem_cluster_es_seq;

  localparam int NC = 8;
  localparam int CW = 14;
  localparam int DW = 10;

  typedef struct packed {
    logic [7:0]     vld;
    logic [NC*DW-1:0] lo;
    logic [NC*DW-1:0] hi;
    logic [63:0]    a0;
    logic [63:0]    a1;
  } set_t;

  logic             clock = 1'b0;
  logic             global_reset;
  logic             clst_start;
  logic [CW*NC-1:0] clst_in;
  logic [7:0]       rom_adr0, rom_adr1;
  logic [DW-1:0]    rom_rd0, rom_rd1;
  logic             busy, es_done, start_lost;
  logic [NC-1:0]    es_vld;
  logic [NC*DW-1:0] es_lo, es_hi;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] rom [256];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_rd0 <= rom[rom_adr0];
    rom_rd1 <= rom[rom_adr1];
  end

  gem_cluster_es_seq dut (
    .clock        (clock),
    .global_reset (global_reset),
    .clst_start   (clst_start),
    .clst_in      (clst_in),
    .rom_adr0     (rom_adr0),
    .rom_adr1     (rom_adr1),
    .rom_rd0      (rom_rd0),
    .rom_rd1      (rom_rd1),
    .busy         (busy),
    .es_done      (es_done),
    .es_vld       (es_vld),
    .es_lo        (es_lo),
    .es_hi        (es_hi),
    .start_lost   (start_lost)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of a whole set, straight from the pad/size/clip/min-max rules.
  function automatic set_t predict(input logic [CW*NC-1:0] c);
    set_t          s;
    logic [7:0]    pad;
    logic [2:0]    sz;
    int            last;
    logic [DW-1:0] a, b;
    s = '0;
    for (int i = 0; i < NC; i++) begin
      pad = c[i*CW +: 8];
      sz  = c[i*CW+11 +: 3];
      if (int'(pad) < 192) begin
        last = int'(pad) + int'(sz);
        if (last > 191) last = 191;
        a = rom[pad];
        b = rom[8'(last)];
        s.vld[i]          = 1'b1;
        s.lo[i*DW +: DW]  = (a < b) ? a : b;
        s.hi[i*DW +: DW]  = (a < b) ? b : a;
        s.a0[i*8 +: 8]    = pad;
        s.a1[i*8 +: 8]    = 8'(last);
      end
    end
    return s;
  endfunction

  // Model: age counts clocks since an accepted start; results appear 10 edges later.
  int               m_age = 0;
  logic             exp_lost = 1'b0;
  logic [NC-1:0]    exp_vld = '0;
  logic [NC*DW-1:0] exp_lo = '0;
  logic [NC*DW-1:0] exp_hi = '0;
  set_t             pend = '0;

  always @(posedge clock) begin
    if (global_reset) begin
      m_age    <= 0;
      exp_lost <= 1'b0;
      exp_vld  <= '0;
      exp_lo   <= '0;
      exp_hi   <= '0;
    end else if (m_age != 0) begin
      if (clst_start) exp_lost <= 1'b1;
      m_age <= (m_age == 11) ? 0 : m_age + 1;
      if (m_age == 10) begin
        exp_vld <= pend.vld;
        exp_lo  <= pend.lo;
        exp_hi  <= pend.hi;
      end
    end else if (clst_start) begin
      m_age <= 1;
      pend  <= predict(clst_in);
    end
  end

  initial begin : compare
    logic [7:0] ea0, ea1;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        ea0 = 8'h0;
        ea1 = 8'h0;
        if (m_age >= 2 && m_age <= 9) begin
          ea0 = pend.a0[(m_age-2)*8 +: 8];
          ea1 = pend.a1[(m_age-2)*8 +: 8];
        end
        chk("busy", 80'(busy), 80'(m_age != 0));
        chk("es_done", 80'(es_done), 80'(m_age == 11));
        chk("start_lost", 80'(start_lost), 80'(exp_lost));
        chk("rom_adr0", 80'(rom_adr0), 80'(ea0));
        chk("rom_adr1", 80'(rom_adr1), 80'(ea1));
        chk("es_vld", 80'(es_vld), 80'(exp_vld));
        chk("es_lo", es_lo, exp_lo);
        chk("es_hi", es_hi, exp_hi);
      end
    end
  end

  function automatic logic [CW*NC-1:0] put(input logic [CW*NC-1:0] c, input int i,
                                           input logic [7:0] pad, input logic [2:0] sz);
    c[i*CW +: CW] = {sz, 3'b000, pad};
    return c;
  endfunction

  function automatic logic [CW*NC-1:0] empty_set();
    logic [CW*NC-1:0] c;
    c = '0;
    for (int i = 0; i < NC; i++) c = put(c, i, 8'hFF, 3'd0);
    return c;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [CW*NC-1:0] c);
    clst_in    = c;
    clst_start = 1'b1;
    tick();
    clst_start = 1'b0;
  endtask

  // Called just after the start edge, which counts as clock 1.
  task automatic wait_done(output int n);
    n = 1;
    while (!es_done && n < 40) begin
      tick();
      n++;
    end
    if (!es_done) chk("done_timeout", 80'(es_done), 80'(1));
  endtask

  initial begin
    logic [CW*NC-1:0] c;
    int               n;
    int               ndone;
    int               k;
    for (int p = 0; p < 256; p++) rom[p] = 10'(4 * p + 2);
    global_reset = 1'b1;
    clst_start   = 1'b0;
    clst_in      = empty_set();
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_vld", 80'(es_vld), 80'(0));
    chk("rst_lo", es_lo, 80'(0));
    global_reset = 1'b0;
    tick();

    // Single cluster, latency.
    c = put(empty_set(), 0, 8'd10, 3'd2);
    pulse_start(c);
    wait_done(n);
    chk("latency", 80'(n), 80'(11));
    chk("single_vld", 80'(es_vld), 80'(8'h01));
    chk("single_lo0", 80'(es_lo[9:0]), 80'(42));
    chk("single_hi0", 80'(es_hi[9:0]), 80'(50));
    chk("single_lo_rest", 80'(es_lo[79:10]), 80'(0));
    chk("single_hi_rest", 80'(es_hi[79:10]), 80'(0));
    tick();
    tick();

    // Clip at the last pad.
    pulse_start(put(empty_set(), 0, 8'd190, 3'd7));
    tick();
    chk("clip_adr0", 80'(rom_adr0), 80'(190));
    chk("clip_adr1", 80'(rom_adr1), 80'(191));
    wait_done(n);
    chk("clip_lo", 80'(es_lo[9:0]), 80'(762));
    chk("clip_hi", 80'(es_hi[9:0]), 80'(766));
    tick();
    tick();

    // Non-monotonic table, plus a size-0 cluster.
    rom[100] = 10'd800;
    rom[103] = 10'd20;
    c = put(put(empty_set(), 0, 8'd100, 3'd3), 5, 8'd50, 3'd0);
    pulse_start(c);
    wait_done(n);
    chk("nonmono_lo", 80'(es_lo[9:0]), 80'(20));
    chk("nonmono_hi", 80'(es_hi[9:0]), 80'(800));
    chk("size0_lo", 80'(es_lo[59:50]), 80'(202));
    chk("size0_hi", 80'(es_hi[59:50]), 80'(202));
    tick();
    tick();
    rom[100] = 10'(4 * 100 + 2);
    rom[103] = 10'(4 * 103 + 2);

    // Start while busy.
    pulse_start(put(empty_set(), 2, 8'd30, 3'd4));
    repeat (3) tick();
    clst_start = 1'b1;
    tick();
    clst_start = 1'b0;
    ndone = 0;
    repeat (20) begin
      if (es_done) ndone++;
      tick();
    end
    chk("one_done", 80'(ndone), 80'(1));
    chk("lost_set", 80'(start_lost), 80'(1));

    // Back-to-back: second start in the first idle cycle after es_done.
    pulse_start(put(empty_set(), 1, 8'd5, 3'd0));
    wait_done(n);
    tick();
    c = '0;
    for (int i = 0; i < NC; i++) c = put(c, i, 8'(20 * i), 3'd1);
    pulse_start(c);
    wait_done(n);
    chk("b2b_latency", 80'(n), 80'(11));
    chk("b2b_vld", 80'(es_vld), 80'(8'hFF));
    chk("b2b_lo3", 80'(es_lo[39:30]), 80'(242));
    chk("b2b_hi3", 80'(es_hi[39:30]), 80'(246));
    chk("b2b_lo7", 80'(es_lo[79:70]), 80'(562));
    chk("b2b_hi7", 80'(es_hi[79:70]), 80'(566));
    chk("lost_sticky", 80'(start_lost), 80'(1));
    tick();

    // Reset in the middle of SCAN.
    pulse_start(c);
    repeat (3) tick();
    global_reset = 1'b1;
    tick();
    chk("mid_rst_busy", 80'(busy), 80'(0));
    chk("mid_rst_vld", 80'(es_vld), 80'(0));
    chk("mid_rst_lo", es_lo, 80'(0));
    chk("mid_rst_hi", es_hi, 80'(0));
    chk("mid_rst_lost", 80'(start_lost), 80'(0));
    global_reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      tick();
      if (es_done) ndone++;
    end
    chk("no_done_after_rst", 80'(ndone), 80'(0));

    // Randomised sets with occasional table perturbation and stray starts.
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) rom[$urandom_range(0, 191)] = 10'($urandom_range(0, 1023));
      c = '0;
      for (int i = 0; i < NC; i++)
        c = put(c, i, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      pulse_start(c);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 7);
        repeat (k) tick();
        clst_start = 1'b1;
        tick();
        clst_start = 1'b0;
      end
      wait_done(n);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gem_cluster_es_seq.md
Name: gem_cluster_es_seq

Overview:
- Sequences up to 8 GEM clusters from one GEM chamber through a dual-port pad-to-eighth-strip lookup ROM.
- The ROM is a 192-entry, 1-clock-latency, two-read-port table. This block drives its two address ports and consumes its two read ports.
- Produces a min/max eighth-strip (ES) window per cluster, plus a valid mask and a done strobe, for the downstream GEM-CSC matcher.
- Results are double-buffered, so they stay stable while the next cluster set is processed.

Parameters:
- MXCLUSTERS, 8: clusters per set; index width 3.
- MXADRB, 8: ROM address width (pad number).
- MXDATB, 10: ES width (0..895).
- MXPADS, 192: number of valid pads; a pad value >= MXPADS marks an empty cluster.
- ROM_LAT, 1: clocks from address register to ROM read data.

Ports:
- clock  in  1  main 40 MHz clock
- global_reset  in  1  synchronous, active-high reset
- clst_start  in  1  one-clock strobe; samples clst_in
- clst_in  in  14*MXCLUSTERS  per cluster: [7:0] pad, [10:8] roll (ignored), [13:11] size (extra pads beyond first)
- rom_adr0  out  MXADRB  first-pad address to ROM port 0
- rom_adr1  out  MXADRB  last-pad address to ROM port 1
- rom_rd0  in  MXDATB  ROM port 0 data
- rom_rd1  in  MXDATB  ROM port 1 data
- busy  out  1  set is being sequenced
- es_done  out  1  one-clock strobe; output bank updated this cycle
- es_vld  out  MXCLUSTERS  per-cluster valid mask
- es_lo  out  MXDATB*MXCLUSTERS  per-cluster lower ES
- es_hi  out  MXDATB*MXCLUSTERS  per-cluster upper ES
- start_lost  out  1  sticky: a clst_start arrived while busy

Behaviour:
- Reset state: all outputs 0; state IDLE; clusters, working bank and output bank cleared.
- Reset mid-operation aborts the set, and the output bank is cleared.
- States:
  - IDLE: clst_start=1 latches clst_in into a cluster buffer, sets idx=0, goes to SCAN.
  - SCAN: issues one cluster per clock, idx 0..7, always all 8 clusters (fixed latency); after idx=7, goes to DRAIN.
  - DRAIN: waits ROM_LAT+1 clocks for the final capture, then goes to DONE.
  - DONE: one clock; copies the working bank to the output bank, pulses es_done, returns to IDLE.
- busy=1 in SCAN, DRAIN and DONE.
- Latency: clst_start sampled high at edge E gives es_done high in the cycle after edge E+8+ROM_LAT+1, i.e. 11 clocks after start for ROM_LAT=1.
- Back-to-back: clst_start is accepted again in the cycle after DONE, in IDLE.
- Address generation (registered):
  - Empty cluster (pad >= 192): rom_adr0 = rom_adr1 = 0.
  - Otherwise: last = pad + size in 9-bit arithmetic, clipped to 191; rom_adr0 = pad, rom_adr1 = last.
  - A valid-tag pipeline of depth ROM_LAT+1 carries {idx, valid} alongside each address.
- Capture: when the tag emerges, the working bank entry idx gets:
  - es_lo = min(rom_rd0, rom_rd1); es_hi = max(rom_rd0, rom_rd1). The ROM table is not monotonic across the ME1b/ME1a boundary, hence the min/max.
  - vld = tag valid; for an empty cluster, lo = hi = 0 and vld = 0.
- Output bank holds its contents until the next DONE and never shows a partially updated set.
- clst_start while busy: ignored, start_lost is set; only global_reset clears start_lost.
- Size 0 gives a single pad; lo = hi when the ROM is monotonic.

Decomposition:
- Shared package gem_pkg holds:
  - cluster field offsets: PAD_LSB=0, PAD_MSB=7, ROLL 8..10, SIZE 11..13, and cluster width 14
  - MXPADS=192, MXCLUSTERS=8
  - ES width 10 and ROM_LAT
  - state encodings IDLE/SCAN/DRAIN/DONE
- One natural sub-module: gem_cluster_edge (combinational first/last pad, clip and empty decode for one cluster word), instantiated once on the idx-muxed cluster.
- The ROM stays external, instantiated alongside in the parent.

Test Plan:
- Bench ROM is loaded with rom[p] = 4p + 2.
- Single cluster: cluster0 pad=10 size=2, others pad=0xFF -> es_done 11 clocks after start; es_vld=8'h01, es_lo0=42, es_hi0=50, all other lo/hi=0.
- Clip: pad=190 size=7 -> rom_adr1=191; es_lo=762, es_hi=766.
- Non-monotonic table: override rom[100]=900-scaled value 800 and rom[103]=20; cluster pad=100 size=3 -> es_lo=20, es_hi=800.
- Start while busy: second clst_start 4 clocks after the first -> ignored, start_lost=1, exactly one es_done; start_lost stays 1 until global_reset.
- Back-to-back: second start in the cycle after es_done with all 8 clusters valid (pads 0, 20, ..., 140, size 1) -> the first set's outputs remain stable until the second es_done, then es_vld=8'hFF with the correct lo/hi values.
- Reset: global_reset asserted in the middle of SCAN -> the next cycle busy=0 and es_vld/es_lo/es_hi/start_lost=0, and no es_done follows.
